uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte producers. It accepts bytes over per-requester valid/ready handshakes, issues each as a single-cycle `data_en` strobe to the UART transmitter, and tracks the transmitter's `tx_busy` through the whole frame. An optional packet lock keeps the grant on one requester until it marks its last byte, so multi-byte messages are never interleaved on the line.

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester handshakes, the transmitter strobe/busy pair and the
// arbiter status outputs into one interface.
//   req_valid/req_data/req_last : requester -> arbiter, byte i at [i*WIDTH +: WIDTH]
//   req_ready                   : arbiter -> requester, one-hot or zero
//   tx_data/tx_data_en          : arbiter -> transmitter, registered
//   tx_busy                     : transmitter -> arbiter
//   grant_id/locked/tx_err      : arbiter status
// Modports: slave = arbiter view, master = environment (requesters + transmitter).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_data_en;
    logic                     tx_busy;
    logic [GW-1:0]            grant_id;
    logic                     locked;
    logic                     tx_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_data_en, grant_id, locked, tx_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_data_en, grant_id, locked, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte
// producers. Each accepted byte becomes a one-cycle tx_data_en strobe; the
// transmitter's tx_busy is then tracked through the whole frame, optionally
// followed by GAP_CYCLES idle clocks. A byte without req_last locks the grant
// to its requester until that requester sends its last byte.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arbiter_if.slave (handshakes, transmitter pair, status)
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = 16;  // shared gap / ack-timeout counter

    typedef enum logic [2:0] {IDLE, HOLD, SEND, BUSY, GAP} state_t;

    state_t             state_reg, state_next;
    logic [GW-1:0]      rr_reg, rr_next;
    logic [GW-1:0]      grant_reg, grant_next;
    logic [WIDTH-1:0]   tx_data_reg, tx_data_next;
    logic               en_reg, en_next;
    logic               locked_reg, locked_next;
    logic               err_reg, err_next;
    logic [CW-1:0]      cnt_reg, cnt_next;

    logic               win_found;
    logic [GW-1:0]      win_idx;
    logic [GW-1:0]      sel_idx;
    logic               grant_ok;
    logic               accept;
    logic               sel_last;
    logic [WIDTH-1:0]   sel_data;
    logic [NUM_REQ-1:0] ready_vec;
    logic [WIDTH-1:0]   data_arr [NUM_REQ];

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] p);
        if (p == GW'(NUM_REQ - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Winner: first valid requester at or above the rr pointer, wrapping.
    // Scanning downward makes the lowest offset the final assignment.
    always_comb begin
        int s;
        win_found = 1'b0;
        win_idx   = '0;
        s         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = int'(rr_reg) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (bus.req_valid[s]) begin
                win_found = 1'b1;
                win_idx   = GW'(s);
            end
        end
    end

    // While locked only the owner is eligible; ready never looks at data.
    assign sel_idx  = (state_reg == HOLD) ? grant_reg : win_idx;
    assign grant_ok = !bus.tx_busy &&
                      (((state_reg == IDLE) && win_found) || (state_reg == HOLD));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = bus.req_data[gi*WIDTH +: WIDTH];
            assign ready_vec[gi] = grant_ok && (sel_idx == GW'(gi));
        end
    endgenerate

    assign accept   = |(bus.req_valid & ready_vec);
    assign sel_last = bus.req_last[sel_idx];
    assign sel_data = data_arr[sel_idx];

    always_comb begin
        state_next   = state_reg;
        rr_next      = rr_reg;
        grant_next   = grant_reg;
        tx_data_next = tx_data_reg;
        en_next      = 1'b0;
        locked_next  = locked_reg;
        err_next     = 1'b0;
        cnt_next     = cnt_reg;
        case (state_reg)
            IDLE, HOLD: begin
                if (accept) begin
                    tx_data_next = sel_data;
                    en_next      = 1'b1;
                    grant_next   = sel_idx;
                    locked_next  = !sel_last;
                    if (sel_last) rr_next = next_ptr(sel_idx);
                    cnt_next     = '0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (bus.tx_busy) begin
                    state_next = BUSY;
                end else if (cnt_reg == CW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte and unlock.
                    err_next    = 1'b1;
                    locked_next = 1'b0;
                    rr_next     = next_ptr(grant_reg);
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            BUSY: begin
                if (!bus.tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_next   = '0;
                        state_next = GAP;
                    end else begin
                        state_next = locked_reg ? HOLD : IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
                    state_next = locked_reg ? HOLD : IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            grant_reg   <= '0;
            tx_data_reg <= '0;
            en_reg      <= 1'b0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            rr_reg      <= rr_next;
            grant_reg   <= grant_next;
            tx_data_reg <= tx_data_next;
            en_reg      <= en_next;
            locked_reg  <= locked_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.tx_data    = tx_data_reg;
    assign bus.tx_data_en = en_reg;
    assign bus.grant_id   = grant_reg;
    assign bus.locked     = locked_reg;
    assign bus.tx_err     = err_reg;
endmodule
